// File: rtl/mxfp8_accumulator.sv
// ============================================================================
// mxfp8_accumulator : saturating signed accumulator for MXFP8 dot-product beats
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mxfp8_accumulator #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [7:0]              in_shift,
  input  logic [7:0]              in_mant,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [31:0]      c_shift_lim = 32'(ACC_W - 9);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ovf;

  logic                     w_accept;
  logic                     w_term_ovf;
  logic [ACC_W:0]           w_mag;
  logic [ACC_W:0]           w_term;
  logic [ACC_W:0]           w_sum;
  logic [ACC_W-1:0]         w_acc_nxt;
  logic                     w_ovf_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_last;

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

  assign w_accept = in_valid & in_ready;

  // Any shift beyond ACC_W-9 pushes an 8-bit mantissa past the sign bit
  assign w_term_ovf = (in_mant != 8'd0) && ({24'd0, in_shift} > c_shift_lim);
  assign w_mag      = {{(ACC_W-7){1'b0}}, in_mant} << in_shift;
  assign w_term     = in_sign ? (~w_mag + 1'b1) : w_mag;
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_term;

  assign w_cnt_nxt = r_count + 1'b1;
  assign w_last    = in_last | (w_cnt_nxt == {CNT_W{1'b1}});

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    w_ovf_nxt = r_ovf;
    if (w_term_ovf) begin
      w_acc_nxt = in_sign ? c_acc_min : c_acc_max;
      w_ovf_nxt = 1'b1;
    end else if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_nxt = w_sum[ACC_W] ? c_acc_min : c_acc_max;
      w_ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // acc/count/ovf are zero whenever IDLE, so the first beat needs no special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end else if (r_state == DONE && out_ready) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/mxfp8_accumulator.md
MXFP8_ACCUMULATOR -- requirements
Module: mxfp8_accumulator

Interface
REQ-001 Parameter ACC_W, default 64, is the signed accumulator width in bits (minimum 16).
REQ-002 Parameter CNT_W, default 9, is the width of the beat counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  product beat offered.
REQ-006 in_ready  output  1  block can accept a beat.
REQ-007 in_sign  input  1  product sign, 1 means negative.
REQ-008 in_shift  input  8  unsigned left-shift amount into the accumulator domain.
REQ-009 in_mant  input  8  unsigned integer mantissa product.
REQ-010 in_last  input  1  marks the final beat of a dot product.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_acc  output  ACC_W  signed two's-complement accumulated sum.
REQ-014 out_count  output  CNT_W  number of beats accumulated.
REQ-015 out_ovf  output  1  sticky saturation flag for this result.

Function
REQ-016 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-017 The term magnitude SHALL be in_mant << in_shift, computed without truncation.
REQ-018 A term with in_sign=1 SHALL be negated, and in_mant=0 SHALL contribute exactly 0 regardless of sign or shift, with no overflow.
REQ-019 A term with nonzero in_mant and in_shift > ACC_W-9 SHALL be treated as overflow: saturate toward the term's sign and set ovf.
REQ-020 Each sum SHALL be formed in ACC_W+1 bits.
REQ-021 A sum above 2^(ACC_W-1)-1 or below -2^(ACC_W-1) SHALL clamp to that bound and set ovf.
REQ-022 ovf SHALL be sticky until the result is consumed, and accumulation SHALL continue saturating after overflow.
REQ-023 The state machine SHALL have three states: IDLE, ACCUM and DONE.
REQ-024 IDLE: acc=0, count=0, ovf=0, in_ready=1, out_valid=0. An accepted beat sets acc=term and count=1, then moves to DONE if in_last=1, else to ACCUM.
REQ-025 ACCUM: in_ready=1, out_valid=0. An accepted beat sets acc=acc+term and count=count+1, then moves to DONE if in_last=1.
REQ-026 ACCUM with in_valid=0 SHALL hold all state.
REQ-027 An accepted beat that brings count to 2^CNT_W-1 SHALL act as an implicit last and move to DONE, even if in_last=0.
REQ-028 DONE: out_valid=1, in_ready=0. in_valid SHALL be ignored.
REQ-029 In DONE, out_acc, out_count and out_ovf SHALL be held stable while out_ready=0.
REQ-030 In DONE with out_ready=1, the block SHALL move to IDLE the next cycle and clear acc, count and ovf. It SHALL NOT accept a new beat in that same cycle.
REQ-031 Latency: out_valid SHALL rise in the cycle after the last beat is accepted.
REQ-032 Throughput SHALL be one beat per cycle in IDLE and ACCUM.
REQ-033 in_ready SHALL be decoded from the state register only, with no combinational path from any input.
REQ-034 out_acc, out_count and out_ovf SHALL be driven directly from registers.

Reset
REQ-035 While rst_n=0, state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0 and in_ready=1.
REQ-036 Assertion of rst_n SHALL take effect immediately (asynchronously), independent of clk.
REQ-037 Deassertion of rst_n SHALL be registered on a clk edge and is treated as synchronous to clk.
REQ-038 Reset during ACCUM or DONE SHALL discard any partial or pending result without emitting it.

Verification
REQ-039 Single beat: sign=0, mant=9, shift=24, last=1 -> next cycle out_valid=1, out_acc=150994944, out_count=1, out_ovf=0.
REQ-040 Mixed signs: beat (0,5,20) then beat (1,3,21,last) -> out_acc=-1048576, out_count=2, out_ovf=0.
REQ-041 Backpressure: result pending with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs constant, no beat consumed; out_ready=1 -> IDLE next cycle.
REQ-042 Overflow: two beats (0,225,55), second with last=1 -> out_acc=2^63-1, out_ovf=1. Single beat (1,1,56,last) -> out_acc=-2^63, out_ovf=1.
REQ-043 Count limit: CNT_W=4, 15 beats of (0,1,0) with last=0 -> DONE after beat 15, out_count=15, out_acc=15.
REQ-044 Reset mid-ACCUM: after 3 beats, pulse rst_n low between clock edges -> outputs zero immediately, in_ready=1, and the next dot product starts from acc=0.
